// File: rtl/div_bcd_conv.sv
// Sequential binary-to-BCD converter driving an external combinational divide-by-10.
// Optional overflow flag (out_ovf) is built only when DIV_BCD_OVF_EN is defined.
module div_bcd_conv #(
  parameter int DIG_NUM = 10,
  parameter int SETTLE  = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_data,
  output logic [31:0]            div_a,
  output logic [31:0]            div_b,
  input  logic [31:0]            div_q,
  input  logic [31:0]            div_r,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*DIG_NUM-1:0]   out_bcd,
  output logic [3:0]             out_ndig
`ifdef DIV_BCD_OVF_EN
  ,
  output logic                   out_ovf
`endif
);

  localparam int             CW       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(SETTLE - 1);
  localparam logic [3:0]     IDX_LAST = 4'(DIG_NUM - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [3:0]    idx;
  logic          sample;
  logic          last;
  logic          unused_r_hi;

  // Only the low nibble of the remainder can be non-zero for a divisor of 10.
  assign unused_r_hi = ^div_r[31:4];

  assign div_b     = 32'd10;
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign sample    = (state == CALC) && (cnt == CNT_LAST);
  assign last      = (div_q == 32'd0) || (idx == IDX_LAST);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: next state gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)        state_nxt = CALC;
      CALC:    if (sample && last)  state_nxt = DONE;
      DONE:    if (out_ready)       state_nxt = IDLE;
      default:                      state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_a    <= '0;
      out_bcd  <= '0;
      out_ndig <= '0;
      idx      <= '0;
      cnt      <= '0;
`ifdef DIV_BCD_OVF_EN
      out_ovf  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            div_a   <= in_data;
            out_bcd <= '0;
            idx     <= '0;
            cnt     <= '0;
`ifdef DIV_BCD_OVF_EN
            out_ovf <= 1'b0;
`endif
          end
        end
        CALC: begin
          if (sample) begin
            for (int k = 0; k < DIG_NUM; k++) begin
              if (idx == 4'(k)) out_bcd[4*k +: 4] <= div_r[3:0];
            end
            // The divider then sees the quotient for a full SETTLE window.
            div_a <= div_q;
            cnt   <= '0;
            if (last) out_ndig <= idx + 4'd1;
            else      idx      <= idx + 4'd1;
`ifdef DIV_BCD_OVF_EN
            if ((idx == IDX_LAST) && (div_q != 32'd0)) out_ovf <= 1'b1;
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_bcd_conv.sv
// Bench for div_bcd_conv: two instances (10 digits/SETTLE=1 and 4 digits/SETTLE=3),
// each with a behavioural divider, a queue-based scoreboard and a decoupled monitor.
module tb_div_bcd_conv;

  localparam int S_A = 1;
  localparam int S_B = 3;

  typedef struct {
    logic [39:0] bcd;
    logic [3:0]  ndig;
    logic        ovf;
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_bad = 0;

  exp_t q_a[$];
  exp_t q_b[$];

  // Instance A: DIG_NUM=10, SETTLE=1
  logic        a_in_valid = 1'b0, a_in_ready, a_out_valid, a_out_ready = 1'b1;
  logic [31:0] a_in_data = '0, a_div_a, a_div_b, a_div_q, a_div_r;
  logic [39:0] a_out_bcd;
  logic [3:0]  a_out_ndig;
  // Instance B: DIG_NUM=4, SETTLE=3
  logic        b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b1;
  logic [31:0] b_in_data = '0, b_div_a, b_div_b, b_div_q, b_div_r;
  logic [15:0] b_out_bcd;
  logic [3:0]  b_out_ndig;
`ifdef DIV_BCD_OVF_EN
  logic a_out_ovf, b_out_ovf;
`endif

  assign a_div_q = (a_div_b != 0) ? a_div_a / a_div_b : 32'd0;
  assign a_div_r = (a_div_b != 0) ? a_div_a % a_div_b : 32'd0;
  assign b_div_q = (b_div_b != 0) ? b_div_a / b_div_b : 32'd0;
  assign b_div_r = (b_div_b != 0) ? b_div_a % b_div_b : 32'd0;

  div_bcd_conv #(.DIG_NUM(10), .SETTLE(S_A)) u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .div_a(a_div_a), .div_b(a_div_b), .div_q(a_div_q), .div_r(a_div_r),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_bcd(a_out_bcd), .out_ndig(a_out_ndig)
`ifdef DIV_BCD_OVF_EN
    , .out_ovf(a_out_ovf)
`endif
  );

  div_bcd_conv #(.DIG_NUM(4), .SETTLE(S_B)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .div_a(b_div_a), .div_b(b_div_b), .div_q(b_div_q), .div_r(b_div_r),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_bcd(b_out_bcd), .out_ndig(b_out_ndig)
`ifdef DIV_BCD_OVF_EN
    , .out_ovf(b_out_ovf)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Caller is positioned at a negedge. Holds the request until accepted, then pushes the expectation.
  task automatic send(input bit sel_b, input logic [31:0] d, input logic [39:0] bcd,
                      input logic [3:0] ndig, input logic ovf);
    exp_t e;
    int   t;
    if (sel_b) begin b_in_valid = 1'b1; b_in_data = d; end
    else       begin a_in_valid = 1'b1; a_in_data = d; end
    t = 0;
    while (!(sel_b ? b_in_ready : a_in_ready) && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) check("accept_timeout", 64'd0, 64'd1);
    e.bcd = bcd; e.ndig = ndig; e.ovf = ovf; e.acc = cyc + 1;
    if (sel_b) q_b.push_back(e);
    else       q_a.push_back(e);
    @(posedge clk);
    #1;
    if (sel_b) begin b_in_valid = 1'b0; b_in_data = '0; end
    else       begin a_in_valid = 1'b0; a_in_data = '0; end
  endtask

  task automatic wait_valid_a();
    int t = 0;
    while (!a_out_valid && t < 200) begin @(negedge clk); t++; end
    if (t >= 200) check("a_valid_timeout", 64'd0, 64'd1);
  endtask

  // Monitors: latency on the rising out_valid, payload on the retiring handshake.
  logic a_prev_v = 1'b0, b_prev_v = 1'b0;
  exp_t ea, eb;

  always @(negedge clk) begin
    if (!rst_n) a_prev_v = 1'b0;
    else begin
      if (a_out_valid && !a_prev_v) begin
        if (q_a.size() == 0) check("a_spurious_valid", 64'd1, 64'd0);
        else check("a_latency", 64'(cyc - q_a[0].acc), 64'(q_a[0].ndig * S_A));
      end
      if (a_out_valid && a_out_ready && q_a.size() > 0) begin
        ea = q_a.pop_front();
        check("a_bcd", 64'(a_out_bcd), 64'(ea.bcd));
        check("a_ndig", 64'(a_out_ndig), 64'(ea.ndig));
`ifdef DIV_BCD_OVF_EN
        check("a_ovf", 64'(a_out_ovf), 64'(ea.ovf));
`endif
      end
      a_prev_v = a_out_valid;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) b_prev_v = 1'b0;
    else begin
      if (b_out_valid && !b_prev_v) begin
        if (q_b.size() == 0) check("b_spurious_valid", 64'd1, 64'd0);
        else check("b_latency", 64'(cyc - q_b[0].acc), 64'(q_b[0].ndig * S_B));
      end
      if (b_out_valid && b_out_ready && q_b.size() > 0) begin
        eb = q_b.pop_front();
        check("b_bcd", 64'(b_out_bcd), 64'(eb.bcd));
        check("b_ndig", 64'(b_out_ndig), 64'(eb.ndig));
`ifdef DIV_BCD_OVF_EN
        check("b_ovf", 64'(b_out_ovf), 64'(eb.ovf));
`endif
      end
      b_prev_v = b_out_valid;
    end
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset values, including the constant divisor while reset is held.
    #12;
    check("rst_in_ready", 64'(a_in_ready), 64'd1);
    check("rst_out_valid", 64'(a_out_valid), 64'd0);
    check("rst_div_a", 64'(a_div_a), 64'd0);
    check("rst_div_b", 64'(a_div_b), 64'd10);
    check("rst_bcd", 64'(a_out_bcd), 64'd0);
    check("rst_ndig", 64'(a_out_ndig), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Main conversions on A, then DONE lasts one cycle with out_ready=1.
    send(1'b0, 32'd12345, 40'h0000012345, 4'd5, 1'b0);
    @(negedge clk);
    wait_valid_a();
    @(negedge clk);
    check("a_idle_after_done", 64'({a_in_ready, a_out_valid}), 64'b10);
    send(1'b0, 32'hFFFF_FFFF, 40'h4294967295, 4'd10, 1'b0);
    @(negedge clk);
    send(1'b0, 32'd0, 40'h0, 4'd1, 1'b0);
    @(negedge clk);
    send(1'b0, 32'd7, 40'h7, 4'd1, 1'b0);
    @(negedge clk);
    send(1'b0, 32'd10, 40'h10, 4'd2, 1'b0);

    // B: SETTLE=3, four digits with truncation at the top digit.
    @(negedge clk);
    send(1'b1, 32'd0, 40'h0, 4'd1, 1'b0);
    @(negedge clk);
    send(1'b1, 32'd123456, 40'h3456, 4'd4, 1'b1);
    @(negedge clk);
    send(1'b1, 32'd9999, 40'h9999, 4'd4, 1'b0);
    @(negedge clk);
    send(1'b1, 32'd10000, 40'h0000, 4'd4, 1'b1);
    @(negedge clk);
    send(1'b1, 32'd42, 40'h42, 4'd2, 1'b0);

    // Back-pressure on A: result held, new request ignored until IDLE.
    @(negedge clk);
    a_out_ready = 1'b0;
    send(1'b0, 32'd500, 40'h500, 4'd3, 1'b0);
    @(negedge clk);
    wait_valid_a();
    a_in_valid = 1'b1;
    a_in_data  = 32'd9;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("hold_in_ready", 64'(a_in_ready), 64'd0);
      check("hold_bcd", 64'(a_out_bcd), 64'h500);
      check("hold_ndig", 64'(a_out_ndig), 64'd3);
    end
    a_out_ready = 1'b1;
    @(negedge clk);
    check("release_idle", 64'({a_in_ready, a_out_valid}), 64'b10);
    send(1'b0, 32'd9, 40'h9, 4'd1, 1'b0);

    // Reset pulse in the middle of CALC; the partial result must vanish.
    @(negedge clk);
    wait_valid_a();
    @(negedge clk);
    send(1'b0, 32'd98765, 40'h98765, 4'd5, 1'b0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", 64'(a_in_ready), 64'd1);
    check("mid_rst_out_valid", 64'(a_out_valid), 64'd0);
    check("mid_rst_div_a", 64'(a_div_a), 64'd0);
    check("mid_rst_bcd", 64'(a_out_bcd), 64'd0);
    check("mid_rst_ndig", 64'(a_out_ndig), 64'd0);
    check("mid_rst_div_b", 64'(a_div_b), 64'd10);
    void'(q_a.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(1'b0, 32'd98765, 40'h98765, 4'd5, 1'b0);

    // Drain both scoreboards with a bounded wait.
    for (int t = 0; t < 1000 && (q_a.size() + q_b.size()) > 0; t++) @(negedge clk);
    check("drain_a", 64'(q_a.size()), 64'd0);
    check("drain_b", 64'(q_b.size()), 64'd0);
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/div_bcd_conv.md
# div_bcd_conv

Sequential binary-to-BCD converter that consumes the combinational 32-bit unsigned divider. It accepts one 32-bit binary value per request, repeatedly divides it by 10 through the external divider, and collects each remainder as one BCD digit. The collected digits are presented on a valid/ready output. It sits directly downstream of the divider and drives the divider's operands itself; the divider's quotient and remainder come back as inputs.

## Interface
Parameters:
- DIG_NUM, 10: number of BCD digits produced. Range 1..10; 10 covers the full 32-bit range.
- SETTLE, 1: cycles each division is given to settle before quotient and remainder are sampled. Must be ≥1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid && in_ready.
- in_data  in  32  unsigned binary value to convert.
- div_a  out  32  dividend to the divider; registered.
- div_b  out  32  divisor to the divider; constant 32'd10.
- div_q  in  32  quotient from the divider.
- div_r  in  32  remainder from the divider; only bits [3:0] are used.
- out_valid  out  1  result valid.
- out_ready  in  1  result consumed when out_valid && out_ready.
- out_bcd  out  4*DIG_NUM  BCD digits; digit k sits in [4k+3:4k], with digit 0 the least significant.
- out_ndig  out  4  number of significant digits; always ≥1.
- out_ovf  out  1  value needed more than DIG_NUM digits. Present only with DIV_BCD_OVF_EN.

## Operation
- Registers: state, work value (drives div_a), digit index idx, settle counter cnt, out_bcd, out_ndig, out_ovf.
- States:
  - IDLE: in_ready=1. On handshake: work←in_data, out_bcd←0, idx←0, cnt←0, out_ovf←0 → CALC.
  - CALC: div_a=work. cnt counts 0..SETTLE-1. When cnt==SETTLE-1:
    - out_bcd digit[idx]←div_r[3:0]; work←div_q; cnt←0.
    - If div_q==0 or idx==DIG_NUM-1: out_ndig←idx+1 → DONE.
    - Otherwise idx←idx+1, stay in CALC.
  - DONE: out_valid=1. out_bcd, out_ndig and out_ovf are held stable. On out_ready → IDLE.
- Digits above out_ndig-1 read 0.
- Truncation: when idx reaches DIG_NUM-1 with div_q≠0, the upper digits are discarded. With DIV_BCD_OVF_EN, out_ovf←1 in this case.
- An input of 0 produces digit0=0 and out_ndig=1.
- in_ready and out_valid are decoded from state. in_ready=1 only in IDLE; out_valid=1 only in DONE.

## Timing
- Reset values (held while rst_n=0): state=IDLE, in_ready=1, out_valid=0, div_a=0, out_bcd=0, out_ndig=0, out_ovf=0, idx=0, cnt=0.
- div_b is 10 at all times, including during reset.
- Latency: for an n-digit result, out_valid rises n×SETTLE cycles after the input handshake edge.
- Throughput: one conversion per n×SETTLE+2 cycles minimum, when out_ready=1 on the first DONE cycle.
- in_valid is ignored outside IDLE; in_data is sampled only at the handshake edge.
- Simultaneous out_ready and in_valid in DONE: the result is retired, and the new request is accepted no earlier than the following IDLE cycle.
- div_a changes only at a sampling edge or the input handshake edge, so the divider sees each operand for exactly SETTLE cycles.
- Reset asserted mid-CALC or mid-DONE: the block returns to IDLE immediately and asynchronously. The partial result is lost and no out_valid is produced.

## Configuration
- DIV_BCD_OVF_EN defined:
  - out_ovf port exists.
  - The comparison div_q≠0 at idx==DIG_NUM-1 is implemented.
  - out_ovf is cleared on each accept and held through DONE.
- DIV_BCD_OVF_EN undefined:
  - No out_ovf port and no check.
  - Truncation is silent.
  - All other behaviour is identical.

## Test plan
- DIG_NUM=10, SETTLE=1, in_data=12345, out_ready=1 → out_valid 5 cycles after accept, out_bcd=40'h0000012345, out_ndig=5, then in_ready=1 the next cycle.
- in_data=0, SETTLE=3 → out_valid 3 cycles after accept, out_bcd=0, out_ndig=1.
- in_data=32'hFFFFFFFF, DIG_NUM=10 → out_bcd=40'h4294967295, out_ndig=10, out_ovf=0.
- DIV_BCD_OVF_EN defined, DIG_NUM=4, in_data=123456 → out_bcd=16'h3456, out_ndig=4, out_ovf=1. Same case without the macro → same digits, no out_ovf port.
- Hold out_ready=0 for 6 cycles in DONE with in_valid=1 → out_bcd and out_ndig stable, in_ready=0. Release out_ready → IDLE next cycle, then the new request is accepted.
- Drop rst_n for 1 cycle mid-CALC of in_data=98765 → all outputs go to reset values at once. Next request 98765 → out_bcd low 20 bits 20'h98765, out_ndig=5.
